// File: rtl/sine_oscillator_bank_pkg.sv
// Shared types and widths for the time-multiplexed oscillator bank.
// Wave modes, sweep FSM states and quadrant type live here so the top and the bench agree.
package sine_oscillator_bank_pkg;

    localparam int AUDIO_BIT_WIDTH = 16;

    typedef enum logic [1:0] {
        SINE     = 2'd0,
        SQUARE   = 2'd1,
        SAW      = 2'd2,
        TRIANGLE = 2'd3
    } wave_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } osc_bank_state_t;

    typedef logic [1:0] quadrant_t;

endpackage

// File: rtl/sine_quarter_rom.sv
// Synchronous quarter-wave sine ROM: entry i = round(PEAK * sin(pi/2 * i / (DEPTH-1))).
// Contents are folded to constants at elaboration; the registered read maps onto block RAM.
module sine_quarter_rom #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] quarter_sine(input int idx);
        real peak;
        real angle;
        peak  = (2.0 ** DATA_WIDTH) - 1.0;
        angle = 1.5707963267948966 * real'(idx) / real'(DEPTH - 1);
        return DATA_WIDTH'($rtoi(peak * $sin(angle) + 0.5));
    endfunction

    logic [DATA_WIDTH-1:0] rom_table [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom_table[gi] = quarter_sine(gi);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data <= rom_table[addr];
        end
    end

endmodule

// File: rtl/sine_oscillator_bank.sv
// VOICES phase accumulators sharing one quarter-wave ROM; each sample_tick sweeps every
// voice in order and streams one signed sample per voice over valid/ready.
module sine_oscillator_bank
    import sine_oscillator_bank_pkg::*;
#(
    parameter int VOICES          = 8,
    parameter int PHASE_WIDTH     = 24,
    parameter int LUT_ADDR_WIDTH  = 8,
    parameter int AUDIO_WIDTH     = AUDIO_BIT_WIDTH,
    localparam int VOICE_WIDTH    = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_tick,
    input  logic [VOICES-1:0]             voice_enable,
    input  wave_mode_t                    wave_mode,
    input  logic                          step_we,
    input  logic [VOICE_WIDTH-1:0]        step_voice,
    input  logic [PHASE_WIDTH-1:0]        step_value,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [VOICE_WIDTH-1:0]        out_voice,
    output logic signed [AUDIO_WIDTH-1:0] out_sample,
    output logic                          busy,
    output logic                          overrun
);

    localparam int MAG_WIDTH = AUDIO_WIDTH - 1;
    localparam logic [MAG_WIDTH-1:0] PEAK = '1;
    localparam logic [VOICE_WIDTH-1:0] LAST_VOICE = VOICE_WIDTH'(VOICES - 1);

    osc_bank_state_t        state_reg;
    logic [VOICE_WIDTH-1:0] voice_reg;
    logic                   valid_reg;
    logic                   busy_reg;
    logic                   overrun_reg;

    logic [PHASE_WIDTH-1:0] phase_table [VOICES];
    logic [PHASE_WIDTH-1:0] step_table  [VOICES];

    // Per-voice snapshot taken in FETCH so EMIT is immune to mid-stall input changes.
    logic [PHASE_WIDTH-1:0] phase_cur_reg;
    logic [PHASE_WIDTH-1:0] step_cur_reg;
    wave_mode_t             mode_reg;
    logic                   enable_reg;

    quadrant_t               fetch_quad;
    logic [LUT_ADDR_WIDTH-1:0] fetch_addr;
    logic [LUT_ADDR_WIDTH-1:0] rom_addr;
    logic [MAG_WIDTH-1:0]      rom_data;

    assign fetch_quad = phase_table[voice_reg][PHASE_WIDTH-1 -: 2];
    assign fetch_addr = phase_table[voice_reg][PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
    assign rom_addr   = fetch_quad[0] ? ~fetch_addr : fetch_addr;

    sine_quarter_rom #(
        .ADDR_WIDTH (LUT_ADDR_WIDTH),
        .DATA_WIDTH (MAG_WIDTH)
    ) u_rom (
        .clk  (clk),
        .en   (state_reg == FETCH),
        .addr (rom_addr),
        .data (rom_data)
    );

    quadrant_t                 emit_quad;
    logic [LUT_ADDR_WIDTH-1:0] emit_addr;
    logic [LUT_ADDR_WIDTH-1:0] emit_fold;
    logic [MAG_WIDTH-1:0]      ramp;

    assign emit_quad = phase_cur_reg[PHASE_WIDTH-1 -: 2];
    assign emit_addr = phase_cur_reg[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
    assign emit_fold = emit_quad[0] ? ~emit_addr : emit_addr;

    if (MAG_WIDTH >= LUT_ADDR_WIDTH) begin : g_ramp_wide
        assign ramp = MAG_WIDTH'(emit_fold) << (MAG_WIDTH - LUT_ADDR_WIDTH);
    end else begin : g_ramp_narrow
        assign ramp = emit_fold[LUT_ADDR_WIDTH-1 -: MAG_WIDTH];
    end

    logic [AUDIO_WIDTH-1:0] folded_mag;
    logic [AUDIO_WIDTH-1:0] sample_next;

    always_comb begin
        folded_mag  = {1'b0, rom_data};
        sample_next = '0;
        if (mode_reg == TRIANGLE) begin
            folded_mag = {1'b0, ramp};
        end
        case (mode_reg)
            SINE, TRIANGLE: sample_next = emit_quad[1] ? -folded_mag : folded_mag;
            SQUARE:         sample_next = emit_quad[1] ? -{1'b0, PEAK} : {1'b0, PEAK};
            default:        sample_next = {~phase_cur_reg[PHASE_WIDTH-1],
                                           phase_cur_reg[PHASE_WIDTH-2 -: AUDIO_WIDTH-1]};
        endcase
        // Outside EMIT the ROM register is not reset, so force a clean zero.
        if (!enable_reg || state_reg != EMIT) begin
            sample_next = '0;
        end
    end

    assign out_sample = sample_next;
    assign out_valid  = valid_reg;
    assign out_voice  = voice_reg;
    assign busy       = busy_reg;
    assign overrun    = overrun_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            voice_reg     <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            phase_cur_reg <= '0;
            step_cur_reg  <= '0;
            mode_reg      <= SINE;
            enable_reg    <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                phase_table[i] <= '0;
                step_table[i]  <= '0;
            end
        end else begin
            if (step_we) begin
                step_table[step_voice] <= step_value;
            end
            if (sample_tick && state_reg != IDLE) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (sample_tick) begin
                        state_reg <= FETCH;
                        voice_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                FETCH: begin
                    phase_cur_reg <= phase_table[voice_reg];
                    step_cur_reg  <= step_table[voice_reg];
                    mode_reg      <= wave_mode;
                    enable_reg    <= voice_enable[voice_reg];
                    valid_reg     <= 1'b1;
                    state_reg     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        // Disabled voices park at phase 0 so a re-enabled note starts clean.
                        phase_table[voice_reg] <= enable_reg ? (phase_cur_reg + step_cur_reg) : '0;
                        valid_reg <= 1'b0;
                        if (voice_reg == LAST_VOICE) begin
                            state_reg <= IDLE;
                            voice_reg <= '0;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= FETCH;
                            voice_reg <= voice_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_oscillator_bank.sv
// Scoreboard bench for sine_oscillator_bank: stimulus pushes expected samples from a
// behavioural model, a negedge monitor pops and compares on every handshake.
module tb_sine_oscillator_bank;
    import sine_oscillator_bank_pkg::*;

    localparam int VOICES = 4;
    localparam int PW     = 16;
    localparam int LAW    = 8;
    localparam int AW     = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_tick;
    logic [VOICES-1:0] voice_enable;
    wave_mode_t    wave_mode;
    logic          step_we;
    logic [1:0]    step_voice;
    logic [PW-1:0] step_value;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_voice;
    logic [AW-1:0] out_sample;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    sine_oscillator_bank #(
        .VOICES         (VOICES),
        .PHASE_WIDTH    (PW),
        .LUT_ADDR_WIDTH (LAW),
        .AUDIO_WIDTH    (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .voice_enable (voice_enable),
        .wave_mode    (wave_mode),
        .step_we      (step_we),
        .step_voice   (step_voice),
        .step_value   (step_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_voice    (out_voice),
        .out_sample   (out_sample),
        .busy         (busy),
        .overrun      (overrun)
    );

    int tests_run = 0;
    int failed    = 0;
    int hs_count  = 0;

    typedef struct {
        int         voice;
        logic [15:0] sample;
    } exp_t;
    exp_t sb[$];

    int step_m  [VOICES];
    int phase_m [VOICES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference sample straight from the waveform definitions, in plain integer/real arithmetic.
    function automatic logic [15:0] ref_sample(input int p, input wave_mode_t m, input bit en);
        int  q, a, f, mag;
        real ang;
        if (!en) return 16'h0000;
        q = p / 16384;
        a = (p / 64) % 256;
        f = (q % 2 == 1) ? 255 - a : a;
        case (m)
            SINE: begin
                ang = 1.5707963267948966 * real'(f) / 255.0;
                mag = $rtoi(32767.0 * $sin(ang) + 0.5);
            end
            TRIANGLE: mag = f * 128;
            SQUARE:   mag = 32767;
            default:  return 16'((p + 32768) % 65536);
        endcase
        return (q >= 2) ? 16'(-mag) : 16'(mag);
    endfunction

    task automatic sweep_model();
        for (int v = 0; v < VOICES; v++) begin
            exp_t e;
            e.voice  = v;
            e.sample = ref_sample(phase_m[v], wave_mode, voice_enable[v]);
            sb.push_back(e);
            phase_m[v] = voice_enable[v] ? (phase_m[v] + step_m[v]) % 65536 : 0;
        end
    endtask

    task automatic write_step(input int v, input int val);
        step_we    = 1'b1;
        step_voice = 2'(v);
        step_value = 16'(val);
        @(posedge clk); #1;
        step_we = 1'b0;
        step_m[v] = val;
    endtask

    // Monitor: compare on each handshake; during stalls the presented sample must hold still.
    logic        hold_active = 1'b0;
    logic [1:0]  hold_voice;
    logic [15:0] hold_sample;

    always @(negedge clk) begin
        if (reset) begin
            hold_active <= 1'b0;
        end else if (out_valid) begin
            if (hold_active) begin
                check("stall_voice", 32'(out_voice), 32'(hold_voice));
                check("stall_sample", 32'(out_sample), 32'(hold_sample));
            end
            if (out_ready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_voice), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("voice", 32'(out_voice), 32'(e.voice));
                    check("sample", 32'(out_sample), 32'(e.sample));
                end
                hold_active <= 1'b0;
            end else begin
                hold_active <= 1'b1;
                hold_voice  <= out_voice;
                hold_sample <= out_sample;
            end
        end
    end

    task automatic do_tick(input int stall_voice, input bit check_latency, input bit extra_tick);
        bit done = 0;
        bit stalled = 0;
        int new_step;
        hs_count = 0;
        sample_tick = 1'b1;
        sweep_model();
        @(posedge clk); #1;
        sample_tick = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (check_latency && c == 0) check("latency_fetch_valid", 32'(out_valid), 32'd0);
            if (check_latency && c == 1) begin
                check("latency_emit_valid", 32'(out_valid), 32'd1);
                check("latency_emit_voice", 32'(out_voice), 32'd0);
            end
            if (extra_tick && c == 1) sample_tick = 1'b1;
            if (extra_tick && c == 2) sample_tick = 1'b0;
            if (!busy && c > 0) begin
                done = 1;
            end else begin
                if (!stalled && out_valid && int'(out_voice) == stall_voice) begin
                    stalled   = 1;
                    out_ready = 1'b0;
                    new_step  = int'($urandom_range(1, 65535));
                    write_step(stall_voice, new_step);
                    repeat (4) begin @(posedge clk); #1; end
                    out_ready = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        check("sweep_done", 32'(done), 32'd1);
        check("handshakes", 32'(hs_count), 32'(VOICES));
    endtask

    initial begin
        bit found;
        reset        = 1'b1;
        sample_tick  = 1'b0;
        voice_enable = '0;
        wave_mode    = SINE;
        step_we      = 1'b0;
        step_voice   = '0;
        step_value   = '0;
        out_ready    = 1'b1;
        for (int v = 0; v < VOICES; v++) begin
            step_m[v]  = 0;
            phase_m[v] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_out_voice", 32'(out_voice), 32'd0);
        check("reset_out_sample", 32'(out_sample), 32'd0);

        // Quarter steps: 0, +peak, 0, -peak; four ticks wrap voice0 back to phase 0.
        voice_enable = 4'hF;
        write_step(0, 16'h4000);
        do_tick(-1, 1, 0);
        for (int i = 0; i < 3; i++) do_tick(-1, 0, 0);

        wave_mode = SQUARE;
        for (int i = 0; i < 4; i++) do_tick(-1, 0, 0);
        wave_mode = SAW;
        for (int i = 0; i < 4; i++) do_tick(-1, 0, 0);
        wave_mode = TRIANGLE;
        write_step(3, 16'h1540);
        for (int i = 0; i < 4; i++) do_tick(-1, 0, 0);

        // Gate: only voice2, then bring voice1 back from phase 0.
        wave_mode = SINE;
        write_step(1, 16'h0900);
        write_step(2, 16'h2345);
        voice_enable = 4'b0100;
        for (int i = 0; i < 2; i++) do_tick(-1, 0, 0);
        voice_enable = 4'b0110;
        for (int i = 0; i < 2; i++) do_tick(-1, 0, 0);

        // Backpressure on voice1 with a step rewrite mid-EMIT, then a sweep using the new step.
        voice_enable = 4'hF;
        do_tick(1, 0, 0);
        do_tick(-1, 0, 0);

        // Overrun: second tick mid-sweep is dropped and sticks.
        check("overrun_before", 32'(overrun), 32'd0);
        do_tick(-1, 0, 1);
        check("overrun_set", 32'(overrun), 32'd1);
        repeat (10) begin @(posedge clk); #1; end
        check("no_extra_sweep_busy", 32'(busy), 32'd0);
        check("no_extra_sweep_queue", 32'(sb.size()), 32'd0);

        // Wrap: step 0xFFFF from phase 0 in SAW exposes 0, 0xFFFF, 0xFFFE.
        wave_mode = SAW;
        voice_enable = 4'b1110;
        do_tick(-1, 0, 0);
        voice_enable = 4'hF;
        write_step(0, 16'hFFFF);
        for (int i = 0; i < 3; i++) do_tick(-1, 0, 0);

        // Randomised sweeps.
        for (int t = 0; t < 25; t++) begin
            int nw;
            nw = int'($urandom_range(0, 2));
            for (int k = 0; k < nw; k++) write_step(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
            voice_enable = 4'($urandom_range(0, 15));
            wave_mode    = wave_mode_t'($urandom_range(0, 3));
            do_tick(int'($urandom_range(0, 5)), 0, 0);
        end

        // Reset while voice2 is stalled in EMIT: outputs drop with no clock edge.
        hs_count = 0;
        sample_tick = 1'b1;
        sweep_model();
        @(posedge clk); #1;
        sample_tick = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (out_valid && out_voice == 2'd2) begin
                found = 1;
                out_ready = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("reached_voice2", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_overrun", 32'(overrun), 32'd0);
        check("async_reset_sample", 32'(out_sample), 32'd0);
        sb.delete();
        for (int v = 0; v < VOICES; v++) begin
            step_m[v]  = 0;
            phase_m[v] = 0;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        wave_mode = SAW;
        voice_enable = 4'hF;
        do_tick(-1, 0, 0);
        check("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
